// File: rtl/tc_bit_serializer_pkg.sv
// Shared encodings and width helper for the two-phase bit serializer.
// FSM states plus the count-width rule used by the top and the bench.
package tc_bit_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int cw_of(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/tc_halfcycle_capture.sv
// Falling-edge capture of a load request: hold register and request toggle.
// rst_q clears the capture by re-aligning the toggle with the acknowledge.
module tc_halfcycle_capture
  import tc_bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_q,
  input  logic             i_load,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_hold,
  output logic             o_req
);

  logic [WIDTH-1:0] r_hold;
  logic             r_req;

  always_ff @(negedge i_clk) begin
    if (i_rst_q) begin
      r_hold <= '0;
      r_req  <= i_ack;
    end else if (i_load && i_ready) begin
      r_hold <= i_data;
      r_req  <= ~i_ack;
    end
  end

  assign o_hold = r_hold;
  assign o_req  = r_req;

endmodule

// File: rtl/tc_bit_serializer.sv
// Parallel-to-serial feeder for a bit memory: load on negedge, bits on posedge.
// Posedge FSM, acknowledge toggle and shift register live here.
module tc_bit_serializer
  import tc_bit_serializer_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    WIDTH     = 8,
  parameter bit    LSB_FIRST = 1'b1,
  localparam int   CW        = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [CW-1:0]    count,
  output logic             done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic             r_rst_q;
  logic             r_ack;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_hold;
  logic             w_req;
  logic             w_pending;
  logic             w_shift;
  logic             w_unused;

  assign w_unused = ^{UUID[0], (NAME == "")};

  tc_halfcycle_capture #(
    .WIDTH(WIDTH)
  ) u_cap (
    .i_clk  (clk),
    .i_rst_q(r_rst_q),
    .i_load (load),
    .i_ready(ready),
    .i_data (data),
    .i_ack  (r_ack),
    .o_hold (w_hold),
    .o_req  (w_req)
  );

  assign w_pending = w_req ^ r_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rst_q <= 1'b1;
      r_ack   <= 1'b0;
      r_shreg <= '0;
      r_count <= '0;
    end else begin
      r_rst_q <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_shreg <= w_hold;
            r_ack   <= ~r_ack;
            r_count <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // final shift leaves zeros, so IDLE sees a clear register
          r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
          if (r_count == LAST) begin
            r_count <= '0;
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_shreg <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign w_shift   = (r_state == ST_SHIFT);
  assign ready     = (r_state == ST_IDLE) & ~r_rst_q;
  assign busy      = w_shift;
  assign bit_valid = w_shift;
  assign done      = (r_state == ST_DONE);
  assign count     = r_count;
  assign bit_out   = w_shift &
    (LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1]);

endmodule

// File: tb/tb_tc_bit_serializer.sv
// Bench: three serializer instances against a timeline reference model.
// Covers LSB/MSB order, WIDTH=2, ignored loads, reset abort, random traffic.
module tb_tc_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = '0;
  logic       load2 = 1'b0;
  logic [1:0] data2 = '0;

  logic       rdy8, bsy8, bo8, bv8, dn8;
  logic [2:0] cnt8;
  logic       rdym, bsym, bom, bvm, dnm;
  logic [2:0] cntm;
  logic       rdy2, bsy2, bo2, bv2, dn2;
  logic [0:0] cnt2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tc_bit_serializer #(.UUID(1), .NAME("lsb"), .WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .ready(rdy8), .busy(bsy8), .bit_out(bo8), .bit_valid(bv8),
    .count(cnt8), .done(dn8)
  );

  tc_bit_serializer #(.UUID(2), .NAME("msb"), .WIDTH(8), .LSB_FIRST(1'b0)) dutm (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .ready(rdym), .busy(bsym), .bit_out(bom), .bit_valid(bvm),
    .count(cntm), .done(dnm)
  );

  tc_bit_serializer #(.UUID(3), .NAME("w2"), .WIDTH(2), .LSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .data(data2),
    .ready(rdy2), .busy(bsy2), .bit_out(bo2), .bit_valid(bv2),
    .count(cnt2), .done(dn2)
  );

  // downstream bit memory fed by the MSB-first instance
  logic mem_m = 1'b0;
  always @(negedge clk) if (bvm) mem_m <= bom;

  logic o_rdy[3], o_bsy[3], o_bit[3], o_bv[3], o_dn[3];
  int   o_cnt[3];
  assign o_rdy[0] = rdy8; assign o_rdy[1] = rdym; assign o_rdy[2] = rdy2;
  assign o_bsy[0] = bsy8; assign o_bsy[1] = bsym; assign o_bsy[2] = bsy2;
  assign o_bit[0] = bo8;  assign o_bit[1] = bom;  assign o_bit[2] = bo2;
  assign o_bv[0]  = bv8;  assign o_bv[1]  = bvm;  assign o_bv[2]  = bv2;
  assign o_dn[0]  = dn8;  assign o_dn[1]  = dnm;  assign o_dn[2]  = dn2;
  assign o_cnt[0] = int'(cnt8);
  assign o_cnt[1] = int'(cntm);
  assign o_cnt[2] = int'(cnt2);

  // reference: phase = posedges since accept (0 idle, 1..W bits, W+1 done)
  int         mw[3] = '{8, 8, 2};
  int         m_ph[3] = '{0, 0, 0};
  logic [7:0] m_w[3];
  logic [7:0] m_pw[3];
  bit         m_pend[3] = '{0, 0, 0};
  bit         m_rstq = 1'b1;

  task automatic chk(input string tag, input int id,
                     input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d] t=%0t observed %0d expected %0d",
             tag, id, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int id = 0; id < 3; id++) begin
      int  ph = m_ph[id];
      bit  sh = (ph >= 1) && (ph <= mw[id]);
      bit  eb = 1'b0;
      if (sh) eb = (id == 1) ? m_w[id][7 - (ph - 1)] : m_w[id][ph - 1];
      chk("ready", id, int'(o_rdy[id]), int'(ph == 0 && !m_rstq));
      chk("busy", id, int'(o_bsy[id]), int'(sh));
      chk("bit_valid", id, int'(o_bv[id]), int'(sh));
      chk("done", id, int'(o_dn[id]), int'(ph == mw[id] + 1));
      chk("bit_out", id, int'(o_bit[id]), int'(eb));
      if (sh) chk("count", id, o_cnt[id], ph - 1);
      if (m_rstq) chk("count_rst", id, o_cnt[id], 0);
      if (id == 1 && ph == mw[id] + 1)
        chk("mem_out", id, int'(mem_m), int'(m_w[1][0]));
    end
  endtask

  // one cycle: drive after posedge, model the negedge capture, check next posedge
  task automatic cyc(input logic r, input logic l, input logic [7:0] d,
                     input logic l2, input logic [1:0] d2);
    rst = r; load = l; data = d; load2 = l2; data2 = d2;
    for (int id = 0; id < 3; id++) begin
      logic       li = (id == 2) ? l2 : l;
      logic [7:0] di = (id == 2) ? {6'd0, d2} : d;
      if (m_rstq) m_pend[id] = 1'b0;
      else if (m_ph[id] == 0 && li) begin
        m_pend[id] = 1'b1;
        m_pw[id] = di;
      end
    end
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      if (r) begin
        m_ph[id] = 0;
        m_pend[id] = 1'b0;
      end else if (m_ph[id] == 0) begin
        if (m_pend[id]) begin
          m_ph[id] = 1;
          m_w[id] = m_pw[id];
          m_pend[id] = 1'b0;
        end
      end else if (m_ph[id] <= mw[id]) begin
        m_ph[id] = m_ph[id] + 1;
      end else begin
        m_ph[id] = 0;
      end
    end
    m_rstq = r;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    idle(1);

    // 0xA5 on both byte instances, 2'b10 on the narrow one
    cyc(1'b0, 1'b1, 8'hA5, 1'b1, 2'b10);
    idle(11);

    // loads during SHIFT/DONE are dropped
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 2'b00);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'hFF, 1'b1, 2'b11);
    idle(4);

    // reset lands on the posedge of the 4th bit of 0x3C
    cyc(1'b0, 1'b1, 8'h3C, 1'b0, 2'd0);
    idle(2);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
    idle(4);

    // reset and load together
    cyc(1'b1, 1'b1, 8'h5A, 1'b1, 2'b01);
    idle(3);

    // load held high with data changing every cycle
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b1, 8'($urandom), 1'b1, 2'($urandom_range(0, 3)));
    idle(12);

    // random traffic with occasional resets
    for (int i = 0; i < 160; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
          8'($urandom), $urandom_range(0, 1) == 1,
          2'($urandom_range(0, 3)));
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tc_bit_serializer.md
# tc_bit_serializer

Upstream feeder for the single-bit memory stage: accepts a parallel word, then emits it one bit per clock on a `bit_out`/`bit_valid` pair that wires directly to a bit-memory's `in`/`save`. It uses the same two-phase timing as the builtin components. The `load` request is captured on the falling edge, and all outputs update on the rising edge, so the downstream bit memory sees stable `in`/`save` at its own falling-edge capture.

## Interface
- `UUID`, default 0: component identifier, unused in logic.
- `NAME`, default "": component label, unused in logic.
- `WIDTH`, default 8: word width in bits, legal range 2..64.
- `LSB_FIRST`, default 1: 1 emits bit 0 first; 0 emits bit WIDTH-1 first.
- `clk`  input  1  single clock; only clock in the block.
- `rst`  input  1  reset, synchronous and active-high.
- `load`  input  1  request to accept `data`; honoured only while `ready`=1.
- `data`  input  WIDTH  word to serialize; sampled with `load`.
- `ready`  output  1  block can accept a `load` in this cycle.
- `busy`  output  1  shifting in progress.
- `bit_out`  output  1  current serial bit; drives the downstream `in`.
- `bit_valid`  output  1  `bit_out` is meaningful; drives the downstream `save`.
- `count`  output  clog2(WIDTH)  index (0-based, in emission order) of the bit on `bit_out`.
- `done`  output  1  one-cycle pulse after the last bit.

## Operation
- The term "cycle k" means the interval after posedge k.
- On posedge with `rst`=1:
  - `ready`, `busy`, `bit_out`, `bit_valid`, `count` and `done` all go to 0.
  - The state goes to IDLE.
  - `rst` is registered as `rst_q`.
- On negedge:
  - If `rst_q`=1, the capture is cleared.
  - Otherwise, if `load`=1 and `ready`=1, `data` is copied into the hold register and a pending request is raised.
- The pending request is implemented as a request/acknowledge toggle pair:
  - The request toggle is written only on negedge.
  - The acknowledge toggle is written only on posedge.
  - Pending is true when the two toggles differ.
  - No register has drivers on both edges.
- States:
  - IDLE: `ready`=1. If pending at posedge, the hold register moves into the shift register, pending is acknowledged, and the state goes to SHIFT with `count`=0.
  - SHIFT: `busy`=1, `bit_valid`=1, `ready`=0. Each posedge advances `count`. After the bit with `count`=WIDTH-1, the state goes to DONE.
  - DONE: `done`=1, `bit_valid`=0, `ready`=0. The next posedge returns to IDLE.
- Bit selection:
  - With `LSB_FIRST`=1, the shift register shifts right and `bit_out` is its bit 0.
  - With `LSB_FIRST`=0, it shifts left and `bit_out` is its bit WIDTH-1.
- `load` while `ready`=0 (SHIFT, DONE, or the first cycle after reset) is ignored. It is neither queued nor an error.
- Once captured, later changes to `data` do not affect the word being emitted.
- In IDLE, `bit_out` holds 0.

## Timing
- `load` is high in cycle k with `ready`=1, and is captured at the negedge in cycle k.
- Posedge k+1 through k+WIDTH: `bit_valid`=1, and bit number i (in emission order) appears at posedge k+1+i.
- Posedge k+WIDTH+1: `bit_valid`=0, `done`=1, `busy`=0.
- Posedge k+WIDTH+2: `done`=0, `ready`=1. A new `load` in this cycle starts the next word at posedge k+WIDTH+3.
- Latency is 1 cycle from the `load` cycle to the first bit. Throughput is one word per WIDTH+2 cycles.
- Reset:
  - `ready` stays 0 through the first cycle after the last reset-high posedge, while `rst_q` clears the capture. It rises at the next posedge.
  - Reset mid-SHIFT aborts immediately. No `done` pulse follows, and the partial word is discarded.
- `rst` and `load` high together: reset wins; nothing is captured.

## Structure
- Shared package holds the state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. The value 3 is illegal and recovers to IDLE.
- Width helper: `CW` = max(1, clog2(WIDTH)).
- Natural sub-module: `tc_halfcycle_capture`, which contains the negedge hold register, the request toggle, and the `rst_q` gating. It is parameterised by WIDTH. The top level holds the posedge FSM, the acknowledge toggle, and the shift register.

## Test plan
- WIDTH=8, LSB_FIRST=1, `data`=0xA5 loaded in cycle 3 -> `bit_out` = 1,0,1,0,0,1,0,1 at posedges 4..11 with `bit_valid`=1; `done` at posedge 12; `ready` at posedge 13.
- LSB_FIRST=0, `data`=0xA5 -> `bit_out` = 1,0,1,0,0,1,0,1 in MSB order, i.e. bits 7..0. Chained into a bit memory, the memory `out` equals 1 one cycle after the last save.
- `load` pulsed with 0xFF during SHIFT of 0x00 -> all 8 bits are 0, `done` pulses once, and no second word is emitted.
- `rst` asserted at the posedge of the 4th bit of 0x3C -> all outputs are 0 at that posedge, there is no `done`, `ready`=0 for one further cycle, and it then becomes 1.
- `load` held high continuously with `data` changing every cycle -> words are accepted only in `ready` cycles, spaced WIDTH+2 apart. Each emitted word equals the `data` value present in its accept cycle.
- WIDTH=2, `data`=2'b10 -> bits 0,1 at posedges k+1 and k+2; `count` goes 0,1; `done` at posedge k+3.
